// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a single uartTx memory-mapped slave.
// Optional BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [3:0]  m0_mem_wstrb,
    input  logic [31:0] m0_mem_wdata,
    input  logic [31:0] m0_mem_addr,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [3:0]  m1_mem_wstrb,
    input  logic [31:0] m1_mem_wdata,
    input  logic [31:0] m1_mem_addr,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_enable,
    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [3:0]  s_mem_wstrb,
    output logic [31:0] s_mem_wdata,
    output logic [31:0] s_mem_addr,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;
    logic   r_just_done;

    logic   w_busy;
    logic   w_sel;
    logic   w_valid_sel;
    logic   w_elig0;
    logic   w_elig1;
    logic   w_done;
    logic   w_to;
    logic   w_finish;

    assign w_busy      = (r_state == BUSY0) || (r_state == BUSY1);
    assign w_sel       = (r_state == BUSY1);
    assign w_valid_sel = w_sel ? m1_mem_valid : m0_mem_valid;

    // The requester just completed (always the one `last` points at) sits out one IDLE cycle.
    assign w_elig0 = m0_mem_valid && !(r_just_done && !r_last);
    assign w_elig1 = m1_mem_valid && !(r_just_done &&  r_last);

    // A dropped request aborts silently, so completion also requires the requester still valid.
    assign w_done   = w_busy && w_valid_sel && s_mem_ready;
    assign w_finish = w_done || w_to;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;

    assign w_to = w_busy && w_valid_sel && !s_mem_ready
                  && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_param;

    assign w_unused_timeout_param = ^32'(TIMEOUT_CYCLES);
    assign w_to = 1'b0;
`endif

    // Arbitration state, last-granted pointer and one-cycle post-completion block.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_just_done <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_just_done <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
                    r_cnt       <= '0;
`endif
                    if (w_elig0 && w_elig1) begin
                        r_state <= r_last ? BUSY0 : BUSY1;
                    end else if (w_elig0) begin
                        r_state <= BUSY0;
                    end else if (w_elig1) begin
                        r_state <= BUSY1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (!w_valid_sel) begin
                        r_state     <= IDLE;
                        r_just_done <= 1'b0;
                    end else if (w_finish) begin
                        r_state     <= IDLE;
                        r_last      <= w_sel;
                        r_just_done <= 1'b1;
                    end else begin
`ifdef UART_ARB_TIMEOUT_EN
                        r_cnt <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_just_done <= 1'b0;
                end
            endcase
        end
    end

    // Slave-side forwarding and requester responses follow the current grant combinationally.
    always_comb begin
        s_enable     = 1'b0;
        s_mem_valid  = 1'b0;
        s_mem_instr  = 1'b0;
        s_mem_wstrb  = 4'h0;
        s_mem_wdata  = 32'h0;
        s_mem_addr   = 32'h0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = 32'h0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = 32'h0;
        timeout      = w_to;

        if (w_busy) begin
            s_enable = 1'b1;
            if (w_sel) begin
                s_mem_valid = m1_mem_valid;
                s_mem_instr = m1_mem_instr;
                s_mem_wstrb = m1_mem_wstrb;
                s_mem_wdata = m1_mem_wdata;
                s_mem_addr  = m1_mem_addr;
                m1_mem_ready = w_finish;
                m1_mem_rdata = w_done ? s_mem_rdata : 32'h0;
            end else begin
                s_mem_valid = m0_mem_valid;
                s_mem_instr = m0_mem_instr;
                s_mem_wstrb = m0_mem_wstrb;
                s_mem_wdata = m0_mem_wdata;
                s_mem_addr  = m0_mem_addr;
                m0_mem_ready = w_finish;
                m0_mem_rdata = w_done ? s_mem_rdata : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus reset and timeout sequences.
// Define UART_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog build.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        resetn;
    logic        m0_mem_valid, m1_mem_valid;
    logic        m0_mem_instr, m1_mem_instr;
    logic [3:0]  m0_mem_wstrb, m1_mem_wstrb;
    logic [31:0] m0_mem_wdata, m1_mem_wdata;
    logic [31:0] m0_mem_addr,  m1_mem_addr;
    logic        m0_mem_ready, m1_mem_ready;
    logic [31:0] m0_mem_rdata, m1_mem_rdata;
    logic        s_enable, s_mem_valid, s_mem_instr;
    logic [3:0]  s_mem_wstrb;
    logic [31:0] s_mem_wdata, s_mem_addr;
    logic        s_mem_ready;
    logic [31:0] s_mem_rdata;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .m0_mem_valid(m0_mem_valid), .m0_mem_instr(m0_mem_instr), .m0_mem_wstrb(m0_mem_wstrb),
        .m0_mem_wdata(m0_mem_wdata), .m0_mem_addr(m0_mem_addr),
        .m0_mem_ready(m0_mem_ready), .m0_mem_rdata(m0_mem_rdata),
        .m1_mem_valid(m1_mem_valid), .m1_mem_instr(m1_mem_instr), .m1_mem_wstrb(m1_mem_wstrb),
        .m1_mem_wdata(m1_mem_wdata), .m1_mem_addr(m1_mem_addr),
        .m1_mem_ready(m1_mem_ready), .m1_mem_rdata(m1_mem_rdata),
        .s_enable(s_enable), .s_mem_valid(s_mem_valid), .s_mem_instr(s_mem_instr),
        .s_mem_wstrb(s_mem_wstrb), .s_mem_wdata(s_mem_wdata), .s_mem_addr(s_mem_addr),
        .s_mem_ready(s_mem_ready), .s_mem_rdata(s_mem_rdata),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0v;
        logic        m1v;
        logic        srdy;
        logic [31:0] srd;
        logic        sen;
        logic        sval;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        m0r;
        logic        m1r;
        logic [31:0] m0d;
        logic [31:0] m1d;
    } vec_t;

    localparam logic [31:0] A = 32'haa;
    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(logic m0v, logic m1v, logic srdy, logic [31:0] srd,
                                logic sen, logic sval, logic [3:0] ws, logic [31:0] wd,
                                logic m0r, logic m1r, logic [31:0] m0d, logic [31:0] m1d);
        vec_t v;
        v.m0v = m0v; v.m1v = m1v; v.srdy = srdy; v.srd = srd;
        v.sen = sen; v.sval = sval; v.wstrb = ws; v.wdata = wd;
        v.m0r = m0r; v.m1r = m1r; v.m0d = m0d; v.m1d = m1d;
        return v;
    endfunction

    function automatic logic [104:0] act_out();
        return {s_enable, s_mem_valid, s_mem_wstrb, s_mem_wdata,
                m0_mem_ready, m1_mem_ready, m0_mem_rdata, m1_mem_rdata, timeout};
    endfunction

    function automatic logic [104:0] exp_out(logic sen, logic sval, logic [3:0] ws, logic [31:0] wd,
                                             logic m0r, logic m1r, logic [31:0] m0d,
                                             logic [31:0] m1d, logic to);
        return {sen, sval, ws, wd, m0r, m1r, m0d, m1d, to};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one cycle, drive inputs shortly after the edge, then let combinational outputs settle.
    task automatic step(input logic m0v, input logic m1v, input logic srdy, input logic [31:0] srd);
        @(posedge clk);
        #1;
        m0_mem_valid = m0v;
        m1_mem_valid = m1v;
        s_mem_ready  = srdy;
        s_mem_rdata  = srd;
        #2;
    endtask

    localparam logic [104:0] ZERO = '0;

    int pulses;

    initial begin
        vecs[0]  = mk(1,0,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[1]  = mk(1,0,0,32'h0, 1,1,4'h1,A,     0,0,32'h0,32'h0);
        vecs[2]  = mk(1,0,1,32'h0, 1,1,4'h1,A,     1,0,32'h0,32'h0);
        vecs[3]  = mk(0,0,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[4]  = mk(0,1,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[5]  = mk(0,1,1,32'h1, 1,1,4'h0,32'h0, 0,1,32'h0,32'h1);
        vecs[6]  = mk(0,0,0,32'h1, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[7]  = mk(1,1,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[8]  = mk(1,1,1,32'h5, 1,1,4'h1,A,     1,0,32'h5,32'h0);
        vecs[9]  = mk(1,1,0,32'h5, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[10] = mk(1,1,1,32'h5, 1,1,4'h0,32'h0, 0,1,32'h0,32'h5);
        vecs[11] = mk(1,1,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[12] = mk(1,1,1,32'h6, 1,1,4'h1,A,     1,0,32'h6,32'h0);
        vecs[13] = mk(1,1,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[14] = mk(1,1,1,32'h7, 1,1,4'h0,32'h0, 0,1,32'h0,32'h7);
        vecs[15] = mk(0,0,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[16] = mk(1,0,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[17] = mk(0,0,0,32'h0, 1,0,4'h1,A,     0,0,32'h0,32'h0);
        vecs[18] = mk(1,1,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);
        vecs[19] = mk(1,1,1,32'h9, 1,1,4'h1,A,     1,0,32'h9,32'h0);
        vecs[20] = mk(0,0,0,32'h0, 0,0,4'h0,32'h0, 0,0,32'h0,32'h0);

        resetn       = 1'b0;
        m0_mem_valid = 1'b0; m1_mem_valid = 1'b0;
        m0_mem_instr = 1'b0; m1_mem_instr = 1'b0;
        m0_mem_wstrb = 4'h1; m1_mem_wstrb = 4'h0;
        m0_mem_wdata = A;    m1_mem_wdata = 32'h0;
        m0_mem_addr  = 32'hffff0040;
        m1_mem_addr  = 32'hffff0040;
        s_mem_ready  = 1'b0;
        s_mem_rdata  = 32'h0;

        #3;
        chk("reset_outputs", 128'(act_out()), 128'(ZERO));
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Single write, slave read, simultaneous requests, and a dropped request.
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].m0v, vecs[i].m1v, vecs[i].srdy, vecs[i].srd);
            chk($sformatf("vec%0d", i), 128'(act_out()),
                128'(exp_out(vecs[i].sen, vecs[i].sval, vecs[i].wstrb, vecs[i].wdata,
                             vecs[i].m0r, vecs[i].m1r, vecs[i].m0d, vecs[i].m1d, 1'b0)));
        end
        chk("write_addr_fwd", 128'(s_mem_addr), 128'(32'h0));

        // Reset in the middle of a BUSY0 transaction.
        step(0, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("busy0_addr", 128'(s_mem_addr), 128'(32'hffff0040));
        chk("busy0_before_reset", 128'(act_out()),
            128'(exp_out(1, 1, 4'h1, A, 0, 0, 32'h0, 32'h0, 0)));
        #1 resetn = 1'b0;
        #1 chk("reset_mid_busy", 128'(act_out()), 128'(ZERO));
        step(1, 0, 1, 32'h3);
        chk("reset_held_no_ready", 128'(act_out()), 128'(ZERO));
        @(posedge clk);
        #1;
        resetn       = 1'b1;
        m0_mem_valid = 1'b1;
        m1_mem_valid = 1'b1;
        s_mem_ready  = 1'b0;
        #2 chk("post_reset_idle", 128'(act_out()), 128'(ZERO));
        step(1, 1, 0, 32'h0);
        chk("post_reset_m0_first", 128'(act_out()),
            128'(exp_out(1, 1, 4'h1, A, 0, 0, 32'h0, 32'h0, 0)));
        step(1, 1, 1, 32'h11);
        chk("post_reset_m0_done", 128'(act_out()),
            128'(exp_out(1, 1, 4'h1, A, 1, 0, 32'h11, 32'h0, 0)));
        step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h22);
        chk("m1_alone_granted", 128'(act_out()),
            128'(exp_out(1, 1, 4'h0, 32'h0, 0, 1, 32'h0, 32'h22, 0)));
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);

        // Slave never responds.
        step(1, 0, 0, 32'hdead);
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 32'hdead);
            chk($sformatf("timeout_cyc%0d", k), 128'(act_out()),
                128'(exp_out(1, 1, 4'h1, A, (k == 4), 0, 32'h0, 32'h0, (k == 4))));
        end
        step(1, 0, 0, 32'hdead);
        chk("after_timeout_idle", 128'(act_out()), 128'(ZERO));
`else
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            step(1, 0, 0, 32'hdead);
            if (m0_mem_ready || m1_mem_ready || timeout) pulses++;
        end
        chk("no_ready_100_cycles", 128'(pulses), 128'(0));
        chk("still_busy", 128'(act_out()),
            128'(exp_out(1, 1, 4'h1, A, 0, 0, 32'h0, 32'h0, 0)));
`endif
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("final_idle", 128'(act_out()), 128'(ZERO));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: BUSY cycles without s_mem_ready before abort (used only with UART_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports m0_mem_valid / m1_mem_valid  input  1  requester N bus request.
REQ-005 SHALL have ports m0_mem_instr / m1_mem_instr  input  1  requester N instruction-fetch flag.
REQ-006 SHALL have ports m0_mem_wstrb / m1_mem_wstrb  input  4  requester N byte strobes; 0 means read.
REQ-007 SHALL have ports m0_mem_wdata / m1_mem_wdata  input  32  requester N write data.
REQ-008 SHALL have ports m0_mem_addr / m1_mem_addr  input  32  requester N address.
REQ-009 SHALL have ports m0_mem_ready / m1_mem_ready  output  1  requester N completion pulse.
REQ-010 SHALL have ports m0_mem_rdata / m1_mem_rdata  output  32  requester N read data.
REQ-011 SHALL have ports s_enable, s_mem_valid, s_mem_instr  output  1 each  to the shared uartTx slave.
REQ-012 SHALL have ports s_mem_wstrb (4), s_mem_wdata (32), s_mem_addr (32)  output  forwarded request to slave.
REQ-013 SHALL have ports s_mem_ready  input  1 and s_mem_rdata  input  32  slave response.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse on aborted transaction.

Function
REQ-015 SHALL implement states IDLE, BUSY0, BUSY1 plus a 1-bit last-granted pointer `last`.
REQ-016 In IDLE, all s_* outputs and both mN_mem_ready SHALL be 0.
REQ-017 In IDLE with exactly one eligible valid requester, it SHALL move to BUSYn for that requester on the next edge.
REQ-018 In IDLE with both eligible and valid, it SHALL grant the requester not equal to `last` (round-robin).
REQ-019 The requester completed on the previous cycle SHALL be ineligible in the first IDLE cycle after completion (no double issue).
REQ-020 In BUSYn, s_enable SHALL be 1 and s_mem_valid/instr/wstrb/wdata/addr SHALL combinationally follow requester n.
REQ-021 In BUSYn with s_mem_ready=1, mn_mem_ready SHALL be 1 and mn_mem_rdata SHALL equal s_mem_rdata in that same cycle; next state IDLE, `last`<=n.
REQ-022 The non-granted requester SHALL see mem_ready=0 and mem_rdata=0 at all times.
REQ-023 In BUSYn, if mn_mem_valid drops before s_mem_ready, it SHALL return to IDLE with no ready pulse and `last` unchanged.
REQ-024 Latency from mN_mem_valid rising in idle to s_mem_valid SHALL be exactly 1 cycle; an idle gap of at least 1 cycle SHALL separate consecutive grants.

Reset
REQ-025 On resetn=0, at any time including mid-transaction, state SHALL be IDLE, `last`=1 (m0 favoured first), timeout counter 0, all outputs 0, with no ready pulse to the interrupted requester.

Configuration
REQ-026 With UART_ARB_TIMEOUT_EN defined, an 8+ bit counter SHALL clear on BUSY entry and increment each BUSY cycle; on reaching TIMEOUT_CYCLES without s_mem_ready it SHALL pulse mn_mem_ready=1, mn_mem_rdata=32'h0, timeout=1, then go to IDLE with `last`<=n.
REQ-027 Without UART_ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied 0, and BUSY SHALL wait indefinitely.

Verification
REQ-028 Reset, then m0 writes addr 32'hffff0040 data 32'haa; slave ready after 1 cycle -> s_mem_wdata=32'haa one cycle after valid, one m0_mem_ready pulse, m1_mem_ready stays 0.
REQ-029 m0 and m1 assert valid on the same cycle after reset -> m0 served first, then m1 after one IDLE cycle; repeat both -> order m0,m1,m0,m1.
REQ-030 m1 reads 32'hffff0040 and slave returns s_mem_rdata=32'h1 -> m1_mem_rdata=32'h1 during the m1_mem_ready cycle; m0_mem_rdata=0.
REQ-031 Assert resetn=0 during BUSY0 before slave ready -> all outputs 0 immediately, no m0_mem_ready; after release m1 wins a simultaneous request only if m0 is idle.
REQ-032 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never ready -> m0_mem_ready=1, rdata 0, timeout=1 on 4th BUSY cycle; without macro, no ready after 100 cycles.
